// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared types and helpers for the iterative shift unit
package shift_seq_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ILL = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // Width of a shift amount; never collapses to zero bits.
    function automatic int shamt_width(input int data_width);
        return (data_width > 1) ? $clog2(data_width) : 1;
    endfunction

endpackage

// File: rtl/shift_seq_unit_step.sv
// rtl/shift_seq_unit_step.sv - one narrow shift step of at most SHIFT_STEP positions
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = 5,
    parameter int SHIFT_STEP = 4
) (
    input  logic [DATA_WIDTH-1:0] acc,
    input  shift_op_e             op,
    input  logic [SHAMT_W-1:0]    step,
    output logic [DATA_WIDTH-1:0] res
);

    // A step never exceeds the largest legal shift amount, so cap the mux there.
    localparam int MAX_K = (SHIFT_STEP < DATA_WIDTH) ? SHIFT_STEP : DATA_WIDTH - 1;

    always_comb begin
        res = acc;
        for (int k = 1; k <= MAX_K; k++) begin
            if (step == SHAMT_W'(k)) begin
                case (op)
                    SH_SLL:  res = acc << k;
                    SH_SRL:  res = acc >> k;
                    SH_SRA:  res = DATA_WIDTH'($signed(acc) >>> k);
                    default: res = acc;
                endcase
            end
        end
    end

endmodule

// File: rtl/shift_seq_unit.sv
// rtl/shift_seq_unit.sv - multi-cycle SLL/SRL/SRA unit with valid/ready handshakes
module shift_seq_unit
    import shift_seq_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int SHIFT_STEP    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               Op,
    input  logic [OPCODE_LENGTH-1:0] ALUCtl,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    Immediate,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    Rd,
    output logic [OPCODE_LENGTH-1:0] Tag,
    output logic                     busy
);

    localparam int SHAMT_W = shamt_width(DATA_WIDTH);
    localparam logic [SHAMT_W:0] STEP_LIM = (SHAMT_W + 1)'(SHIFT_STEP);

    state_e                     state_q, state_d;
    shift_op_e                  op_q;
    logic [DATA_WIDTH-1:0]      acc_q, acc_next;
    logic [OPCODE_LENGTH-1:0]   tag_q;
    logic [SHAMT_W-1:0]         rem_q, step, load_rem;
    logic                       accept;
    logic                       imm_unused;

    assign imm_unused = ^Immediate[DATA_WIDTH-1:SHAMT_W];

    // Illegal op degenerates to a pass-through by never shifting.
    assign load_rem = (Op == SH_ILL) ? '0 : Immediate[SHAMT_W-1:0];
    assign step     = ({1'b0, rem_q} <= STEP_LIM) ? rem_q : STEP_LIM[SHAMT_W-1:0];

    shift_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHAMT_W    (SHAMT_W),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_step (
        .acc  (acc_q),
        .op   (op_q),
        .step (step),
        .res  (acc_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            op_q    <= SH_SLL;
            tag_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                acc_q <= SrcA;
                op_q  <= shift_op_e'(Op);
                tag_q <= ALUCtl;
                rem_q <= load_rem;
            end else if (state_q == SHIFT && !flush) begin
                acc_q <= acc_next;
                rem_q <= rem_q - step;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid && !flush) begin
                    accept  = 1'b1;
                    state_d = (load_rem == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (rem_q == step) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    assign Rd  = acc_q;
    assign Tag = tag_q;

endmodule

// File: tb/tb_shift_seq_unit.sv
// tb/tb_shift_seq_unit.sv - table-driven scoreboard bench for shift_seq_unit
module tb_shift_seq_unit;
    import shift_seq_pkg::*;

    localparam int DW = 32;
    localparam int OL = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    op = 2'b00;
    logic [OL-1:0] alu_ctl = '0;
    logic [DW-1:0] src_a = '0;
    logic [DW-1:0] imm = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] rd;
    logic [OL-1:0] tag;
    logic          busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] rd;
        logic [OL-1:0] tag;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [1:0]    op;
        logic [OL-1:0] tag;
        logic [DW-1:0] a;
        logic [DW-1:0] imm;
        logic [DW-1:0] rd;
        int            lat;
    } vec_t;
    vec_t vecs[10];

    always #5 clk = ~clk;

    shift_seq_unit #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL), .SHIFT_STEP(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Op        (op),
        .ALUCtl    (alu_ctl),
        .SrcA      (src_a),
        .Immediate (imm),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Rd        (rd),
        .Tag       (tag),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; on return the bench sits in cycle 1.
    task automatic drive_req(input logic [1:0] o, input logic [OL-1:0] t,
                             input logic [DW-1:0] a, input logic [DW-1:0] i);
        check("in_ready_at_issue", {31'b0, in_ready}, 32'd1);
        op = o; alu_ctl = t; src_a = a; imm = i; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; op = ~o; src_a = ~a; alu_ctl = ~t; imm = ~i;
    endtask

    task automatic issue(input logic [1:0] o, input logic [OL-1:0] t,
                         input logic [DW-1:0] a, input logic [DW-1:0] i, input logic [DW-1:0] exp_rd);
        sb.push_back('{rd: exp_rd, tag: t});
        drive_req(o, t, a, i);
    endtask

    task automatic pop_compare(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({name, "_valid"}, {31'b0, out_valid}, 32'd1);
            check({name, "_rd"}, rd, e.rd);
            check({name, "_tag"}, {28'b0, tag}, {28'b0, e.tag});
        end
    endtask

    task automatic wait_valid(input string name, input int exp_lat);
        int cyc = 1;
        while (!out_valid && cyc < 64) begin
            tick();
            cyc++;
        end
        check({name, "_latency"}, cyc, exp_lat);
    endtask

    task automatic await_result(input string name, input int exp_lat);
        wait_valid(name, exp_lat);
        pop_compare(name);
        tick();
        check({name, "_valid_drops"}, {31'b0, out_valid}, 32'd0);
        check({name, "_ready_again"}, {31'b0, in_ready}, 32'd1);
    endtask

    task automatic no_result_for(input string name, input int n);
        int seen = 0;
        for (int c = 0; c < n; c++) begin
            tick();
            if (out_valid) seen++;
        end
        check(name, seen, 0);
    endtask

    initial begin
        vecs[0] = '{2'b01, 4'h1, 32'h0000_0010, 32'd2,     32'h0000_0004, 2};
        vecs[1] = '{2'b01, 4'h2, 32'hFFFF_FFFF, 32'h24,    32'h0FFF_FFFF, 2};
        vecs[2] = '{2'b10, 4'h3, 32'h8000_0000, 32'd31,    32'hFFFF_FFFF, 9};
        vecs[3] = '{2'b00, 4'h4, 32'h0000_0001, 32'd31,    32'h8000_0000, 9};
        vecs[4] = '{2'b00, 4'h5, 32'h0000_0001, 32'd0,     32'h0000_0001, 1};
        vecs[5] = '{2'b11, 4'h6, 32'h1234_5678, 32'd7,     32'h1234_5678, 1};
        vecs[6] = '{2'b10, 4'h7, 32'h7FFF_FFF0, 32'd4,     32'h07FF_FFFF, 2};
        vecs[7] = '{2'b00, 4'h8, 32'hA5A5_A5A5, 32'd5,     32'hB4B4_B4A0, 3};
        vecs[8] = '{2'b10, 4'h9, 32'h8000_0000, 32'd8,     32'hFF80_0000, 3};
        vecs[9] = '{2'b01, 4'hA, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 9};

        repeat (2) tick();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_rd", rd, 32'd0);
        check("rst_tag", {28'b0, tag}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        reset = 1'b0;
        tick();

        for (int v = 0; v < 10; v++) begin
            issue(vecs[v].op, vecs[v].tag, vecs[v].a, vecs[v].imm, vecs[v].rd);
            check($sformatf("vec%0d_busy", v), {31'b0, busy}, 32'd1);
            await_result($sformatf("vec%0d", v), vecs[v].lat);
        end

        // Backpressure while a second request waits at the input.
        out_ready = 1'b0;
        issue(2'b01, 4'h5, 32'h0000_0010, 32'd2, 32'h0000_0004);
        wait_valid("bp", 2);
        op = 2'b00; alu_ctl = 4'h9; src_a = 32'd3; imm = 32'd1; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            check("bp_hold_rd", rd, 32'h0000_0004);
            check("bp_hold_tag", {28'b0, tag}, 32'h5);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        pop_compare("bp_first");
        tick();
        check("bp_idle_ready", {31'b0, in_ready}, 32'd1);
        sb.push_back('{rd: 32'd6, tag: 4'h9});
        tick();
        in_valid = 1'b0;
        await_result("bp_second", 2);

        // Flush in cycle 2 of an SRA by 20.
        drive_req(2'b10, 4'hC, 32'h8000_0000, 32'd20);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        no_result_for("flush_no_result", 10);

        // Flush together with in_valid in IDLE must not accept.
        op = 2'b00; alu_ctl = 4'hD; src_a = 32'd1; imm = 32'd3; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        check("flush_idle_not_accepted", {31'b0, busy}, 32'd0);
        no_result_for("flush_idle_no_result", 4);

        // Flush beats out_ready in DONE.
        out_ready = 1'b0;
        drive_req(2'b00, 4'hE, 32'd1, 32'd0);
        check("done_before_flush", {31'b0, out_valid}, 32'd1);
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_done_valid", {31'b0, out_valid}, 32'd0);
        check("flush_done_busy", {31'b0, busy}, 32'd0);

        // Asynchronous reset in the middle of SHIFT.
        drive_req(2'b00, 4'h7, 32'h0000_0001, 32'd20);
        tick();
        #2 reset = 1'b1;
        #1;
        check("arst_rd", rd, 32'd0);
        check("arst_tag", {28'b0, tag}, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_in_ready", {31'b0, in_ready}, 32'd1);
        check("arst_out_valid", {31'b0, out_valid}, 32'd0);
        #2 reset = 1'b0;
        no_result_for("arst_no_result", 10);

        issue(2'b10, 4'h3, 32'hF000_0000, 32'd6, 32'hFFC0_0000);
        await_result("post_reset", 3);

        check("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_seq_unit.md
Name: shift_seq_unit

Overview:
- Multi-cycle controller that sequences a narrow shift step over several clocks to implement SLL/SRL/SRA (register and immediate forms: SLLI/SRLI/SRAI) for the execute stage.
- Replaces a full single-cycle barrel shifter with an iterative datapath of at most SHIFT_STEP bit positions per cycle.
- valid/ready handshake on both the request and result sides.
- Used by the pipeline as a stall-generating functional unit next to the ALU.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- OPCODE_LENGTH, 4, width of the ALU control field carried through with the request as the result tag.
- SHIFT_STEP, 4, maximum bit positions shifted per cycle; must be ≥1 and ≤ DATA_WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- Op  in  2  shift operation: 00 SLL, 01 SRL, 10 SRA, 11 illegal.
- ALUCtl  in  OPCODE_LENGTH  request tag, returned unchanged on Tag.
- SrcA  in  DATA_WIDTH  value to shift.
- Immediate  in  DATA_WIDTH  shift amount source; only bits [SHAMT_W-1:0] are used, where SHAMT_W = $clog2(DATA_WIDTH).
- flush  in  1  synchronous abort from the pipeline.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- Rd  out  DATA_WIDTH  shifted result.
- Tag  out  OPCODE_LENGTH  ALUCtl of the request that produced Rd.
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- Reset (asynchronous): state=IDLE; out_valid=0, Rd=0, Tag=0, busy=0, in_ready=1; internal acc and remaining cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch acc=SrcA, op=Op, Tag=ALUCtl, remaining=Immediate[SHAMT_W-1:0].
  - Op=11 forces remaining=0, so the result is SrcA unchanged.
  - remaining==0 → DONE; otherwise → SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle: step = min(remaining, SHIFT_STEP); acc shifted by step; remaining -= step.
  - Shift fill: SLL fills with zeros at the LSB; SRL fills with zeros at the MSB; SRA replicates acc[DATA_WIDTH-1] into the MSBs.
  - When remaining == step (the last step) → DONE.
- DONE:
  - out_valid=1; Rd=acc, held stable while out_ready=0.
  - On out_ready → IDLE; out_valid falls the next cycle.
  - A new request is not accepted in the same cycle (in_ready=0 in DONE); minimum issue interval is 2 cycles.
- Latency: taking the accept cycle as cycle 0, out_valid first asserts in cycle 1 + ceil(shamt/SHIFT_STEP). shamt=0 → cycle 1; shamt=31 with step 4 → cycle 9.
- Rd outside DONE: Rd shows acc. Only out_valid qualifies Rd.
- Arithmetic: all arithmetic is modulo DATA_WIDTH; Immediate bits above SHAMT_W are ignored (Immediate=0x24 → shamt 4).
- flush:
  - In any state → IDLE on the next edge.
  - out_valid drops; the result is discarded and not presented.
  - flush together with in_valid in IDLE → request is not accepted.
  - flush has priority over out_ready.
- Reset mid-operation: immediate return to the reset values; no result is produced.
- Op and SrcA changing while busy have no effect (latched at accept).

Decomposition:
- Package shift_seq_pkg:
  - enum shift_op_e {SH_SLL, SH_SRL, SH_SRA, SH_ILL};
  - enum state_e {IDLE, SHIFT, DONE};
  - function computing SHAMT_W from DATA_WIDTH.
- Sub-module shift_step (combinational): inputs acc, op, step; output is acc shifted by step with the correct fill. It is instantiated once inside shift_seq_unit; the FSM, counters and handshake stay in the top module.

Test Plan:
- SRL, SrcA=0x00000010, Immediate=2, out_ready=1 → Rd=0x00000004, out_valid in cycle 2, then in_ready high again.
- SRL, SrcA=0xFFFFFFFF, Immediate=0x24 (shamt 4) → Rd=0x0FFFFFFF, out_valid in cycle 2; covers masking of upper Immediate bits.
- SRA, SrcA=0x80000000, Immediate=31 → Rd=0xFFFFFFFF, out_valid in cycle 9; then SLL, SrcA=0x00000001, Immediate=31 → Rd=0x80000000.
- SLL, SrcA=0x00000001, Immediate=0 → Rd=0x00000001 in cycle 1; Op=11, SrcA=0x12345678, Immediate=7 → Rd=0x12345678 in cycle 1.
- Backpressure: out_ready=0 for 5 cycles after out_valid → Rd, Tag and out_valid stay stable, in_ready=0, and a second in_valid is ignored until accepted.
- flush in cycle 2 of an SRA by 20, then reset asserted mid-SHIFT on another request → out_valid never rises; state returns to IDLE; after reset Rd=0, busy=0, in_ready=1.
